// File: rtl/pred_writeback_sequencer.sv
// pred_writeback_sequencer: FIFO-buffered writeback plus warp-clear FSM driving the predicate file.
// Optional PRED_WB_MERGE_EN: pop a same-warp/same-addr head pair as one merged write.
module pred_writeback_sequencer #(
  parameter int NUM_LANES  = 8,
  parameter int NUM_REGS   = 32,
  parameter int NUM_WARPS  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int WW = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WW-1:0]        req_warp,
  input  logic [AW-1:0]        req_addr,
  input  logic [NUM_LANES-1:0] req_mask,
  input  logic [NUM_LANES-1:0] req_data,
  input  logic                 init_valid,
  output logic                 init_ready,
  input  logic [WW-1:0]        init_warp,
  output logic [NUM_LANES-1:0] write_en,
  output logic [AW-1:0]        waddr,
  output logic [NUM_LANES-1:0] wdata,
  output logic [WW-1:0]        warp_selector,
  output logic                 busy,
  output logic                 init_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = AW + 1;

  typedef struct packed {
    logic [WW-1:0]        warp;
    logic [AW-1:0]        addr;
    logic [NUM_LANES-1:0] mask;
    logic [NUM_LANES-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE,
    INIT
  } state_e;

  state_e               state_q, state_d;
  entry_t               mem_q [FIFO_DEPTH];
  logic [CW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count;
  logic                 fifo_empty, fifo_full;
  logic                 push;
  logic [1:0]           pop_n;
  entry_t               head, req_entry;
  logic [WW-1:0]        warp_q, warp_d;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic [NUM_LANES-1:0] we_q, we_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [NUM_LANES-1:0] wdata_q, wdata_d;
  logic [WW-1:0]        wsel_q, wsel_d;
  logic                 busy_q, done_q, done_d;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign req_ready  = !fifo_full;
  assign init_ready = (state_q == IDLE) && fifo_empty;
  assign push       = req_valid && req_ready;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  assign req_entry = '{
    warp: req_warp,
    addr: req_addr,
    mask: req_mask,
    data: req_data
  };

`ifdef PRED_WB_MERGE_EN
  logic [CW-1:0] rd_ptr_p1;
  entry_t        nxt;
  logic          pair_hit;

  assign rd_ptr_p1 = rd_ptr_q + CW'(1);
  assign nxt       = mem_q[rd_ptr_p1[PW-1:0]];
  assign pair_hit  = (count >= CW'(2))
                  && (nxt.warp == head.warp)
                  && (nxt.addr == head.addr);
`endif

  always_comb begin
    state_d = state_q;
    warp_d  = warp_q;
    cnt_d   = cnt_q;
    pop_n   = 2'd0;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wsel_d  = wsel_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_valid && init_ready) begin
          state_d = INIT;
          warp_d  = init_warp;
          cnt_d   = '0;
        end else if (!fifo_empty) begin
          pop_n   = 2'd1;
          we_d    = head.mask;
          waddr_d = head.addr;
          wdata_d = head.data;
          wsel_d  = head.warp;
`ifdef PRED_WB_MERGE_EN
          // Younger entry wins on lanes it enables.
          if (pair_hit) begin
            pop_n   = 2'd2;
            we_d    = head.mask | nxt.mask;
            wdata_d = (nxt.mask & nxt.data)
                    | (~nxt.mask & head.data);
          end
`endif
        end
      end
      INIT: begin
        if (cnt_q == NW'(NUM_REGS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          we_d    = '1;
          waddr_d = cnt_q[AW-1:0];
          wdata_d = '0;
          wsel_d  = warp_q;
          cnt_d   = cnt_q + NW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      warp_q   <= '0;
      cnt_q    <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wsel_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      warp_q   <= warp_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wsel_q   <= wsel_d;
      done_q   <= done_d;
      busy_q   <= (state_q != IDLE) || !fifo_empty;
      rd_ptr_q <= rd_ptr_q + CW'(pop_n);
      if (push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= req_entry;
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
    end
  end

  assign write_en      = we_q;
  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign warp_selector = wsel_q;
  assign busy          = busy_q;
  assign init_done     = done_q;

endmodule

// File: tb/tb_pred_writeback_sequencer.sv
// Randomized + directed bench for pred_writeback_sequencer.
// Reference model: request queue plus a scheduled list of clear beats.
`timescale 1ns/1ps
module tb_pred_writeback_sequencer;

  localparam int NL = 8;
  localparam int NR = 32;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_warp = '0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_mask = '0;
  logic [7:0] req_data = '0;
  logic       init_valid = 1'b0;
  logic       init_ready;
  logic [2:0] init_warp = '0;
  logic [7:0] write_en;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [2:0] warp_selector;
  logic       busy;
  logic       init_done;

  always #5 clk = ~clk;

  pred_writeback_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_warp      (req_warp),
    .req_addr      (req_addr),
    .req_mask      (req_mask),
    .req_data      (req_data),
    .init_valid    (init_valid),
    .init_ready    (init_ready),
    .init_warp     (init_warp),
    .write_en      (write_en),
    .waddr         (waddr),
    .wdata         (wdata),
    .warp_selector (warp_selector),
    .busy          (busy),
    .init_done     (init_done)
  );

  typedef struct {
    logic [2:0] w;
    logic [4:0] a;
    logic [7:0] m;
    logic [7:0] d;
  } req_t;

  typedef struct {
    logic       done;
    logic [4:0] a;
    logic [2:0] w;
  } beat_t;

  req_t  fifo_m[$];
  beat_t sched[$];

  logic [7:0] e_we, e_wdata;
  logic [4:0] e_waddr;
  logic [2:0] e_wsel;
  logic       e_busy, e_done;
  bit         push_acc, init_acc;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_req_ready();
    return fifo_m.size() < FD;
  endfunction

  function automatic bit m_init_ready();
    return (sched.size() == 0) && (fifo_m.size() == 0);
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    sched.delete();
    e_we = '0;
    e_wdata = '0;
    e_waddr = '0;
    e_wsel = '0;
    e_busy = 1'b0;
    e_done = 1'b0;
  endtask

  // One clock edge of the reference: pending clear beats first,
  // else start a clear, else drain the request queue.
  task automatic model_edge();
    req_t  r, h;
    beat_t b;
    bit    busy_now;
    busy_now = (sched.size() != 0) || (fifo_m.size() != 0);
    push_acc = req_valid && m_req_ready();
    init_acc = init_valid && m_init_ready();
    r = '{req_warp, req_addr, req_mask, req_data};
    e_we = '0;
    e_done = 1'b0;
    if (sched.size() != 0) begin
      b = sched.pop_front();
      if (b.done) begin
        e_done = 1'b1;
      end else begin
        e_we = 8'hFF;
        e_waddr = b.a;
        e_wdata = 8'h00;
        e_wsel = b.w;
      end
    end else if (init_acc) begin
      for (int i = 0; i < NR; i++) begin
        sched.push_back('{1'b0, 5'(i), init_warp});
      end
      sched.push_back('{1'b1, 5'd0, 3'd0});
    end else if (fifo_m.size() != 0) begin
      h = fifo_m.pop_front();
      e_we = h.m;
      e_waddr = h.a;
      e_wdata = h.d;
      e_wsel = h.w;
`ifdef PRED_WB_MERGE_EN
      if (fifo_m.size() != 0 && fifo_m[0].w == h.w
          && fifo_m[0].a == h.a) begin
        req_t n;
        n = fifo_m.pop_front();
        e_we = h.m | n.m;
        for (int i = 0; i < NL; i++) begin
          e_wdata[i] = n.m[i] ? n.d[i] : h.d[i];
        end
      end
`endif
    end
    if (push_acc) fifo_m.push_back(r);
    e_busy = busy_now;
  endtask

  task automatic compare_all();
    chk("write_en", 32'(write_en), 32'(e_we));
    chk("waddr", 32'(waddr), 32'(e_waddr));
    chk("wdata", 32'(wdata), 32'(e_wdata));
    chk("warp_selector", 32'(warp_selector), 32'(e_wsel));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("req_ready", 32'(req_ready), 32'(m_req_ready()));
    chk("init_ready", 32'(init_ready), 32'(m_init_ready()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    init_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_write_en", 32'(write_en), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  task automatic set_req(logic [2:0] w, logic [4:0] a,
                         logic [7:0] m, logic [7:0] d);
    req_valid = 1'b1;
    req_warp = w;
    req_addr = a;
    req_mask = m;
    req_data = d;
  endtask

  task automatic start_init(logic [2:0] w);
    init_valid = 1'b1;
    init_warp = w;
    step();
    chk("init_accept", 32'(init_acc), 32'h1);
    init_valid = 1'b0;
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    init_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_done(string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      step();
      if (init_done === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'h1);
  endtask

  initial begin
    int  cnt, waits;
    bit  acc, seen;

    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single request
    set_req(3'd3, 5'h1F, 8'hFF, 8'hA5);
    step();
    req_valid = 1'b0;
    step();
    chk("t1_we", 32'(write_en), 32'hFF);
    chk("t1_waddr", 32'(waddr), 32'h1F);
    chk("t1_wdata", 32'(wdata), 32'hA5);
    chk("t1_wsel", 32'(warp_selector), 32'h3);
    step();
    chk("t1_we_off", 32'(write_en), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);

    // warp clear
    start_init(3'd5);
    cnt = 0;
    for (int i = 0; i < NR + 1; i++) begin
      step();
      if (write_en == 8'hFF && warp_selector == 3'd5
          && wdata == 8'h00 && waddr == 5'(cnt)) cnt++;
    end
    chk("t2_writes", 32'(cnt), 32'd32);
    chk("t2_done", 32'(init_done), 32'h1);
    step();
    chk("t2_done_pulse", 32'(init_done), 32'h0);
    chk("t2_init_ready", 32'(init_ready), 32'h1);

    // backpressure during clear
    start_init(3'd6);
    for (int k = 0; k < 5; k++) begin
      set_req(3'(k), 5'(k + 1), 8'($urandom_range(1, 255)),
              8'($urandom));
      acc = 1'b0;
      waits = 0;
      for (int c = 0; c < 100 && !acc; c++) begin
        step();
        if (push_acc) acc = 1'b1;
        else waits++;
      end
      chk("t3_accept", 32'(acc), 32'h1);
      if (k == 4) chk("t3_wait5", 32'(waits > 0), 32'h1);
      else chk("t3_nowait", 32'(waits), 32'h0);
    end
    req_valid = 1'b0;
    idle(8);

    // empty mask
    set_req(3'd2, 5'd7, 8'h00, 8'hFF);
    step();
    req_valid = 1'b0;
    step();
    chk("t4_we", 32'(write_en), 32'h0);
    chk("t4_waddr", 32'(waddr), 32'h7);
    chk("t4_wsel", 32'(warp_selector), 32'h2);
    chk("t4_busy_hi", 32'(busy), 32'h1);
    step();
    chk("t4_busy_lo", 32'(busy), 32'h0);

    // reset during clear
    start_init(3'd4);
    set_req(3'd1, 5'd9, 8'hF0, 8'h33);
    step();
    set_req(3'd1, 5'd10, 8'h0F, 8'h44);
    step();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      step();
      if (write_en == 8'hFF && waddr == 5'd10) seen = 1'b1;
    end
    chk("t5_reach10", 32'(seen), 32'h1);
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (write_en != 8'h00 || init_done) seen = 1'b1;
    end
    chk("t5_no_writes", 32'(seen), 32'h0);
    chk("t5_req_ready", 32'(req_ready), 32'h1);
    chk("t5_init_ready", 32'(init_ready), 32'h1);

    // same-target pair queued behind a clear
    start_init(3'd0);
    set_req(3'd1, 5'd4, 8'h0F, 8'h05);
    step();
    set_req(3'd1, 5'd4, 8'h3C, 8'h28);
    step();
    req_valid = 1'b0;
    wait_done("t6_done");
    step();
`ifdef PRED_WB_MERGE_EN
    chk("t6_we", 32'(write_en), 32'h3F);
    chk("t6_wdata", 32'(wdata), 32'h29);
    step();
    chk("t6_we2", 32'(write_en), 32'h0);
`else
    chk("t6_we", 32'(write_en), 32'h0F);
    chk("t6_wdata", 32'(wdata), 32'h05);
    step();
    chk("t6_we2", 32'(write_en), 32'h3C);
    chk("t6_wdata2", 32'(wdata), 32'h28);
`endif
    idle(4);

    // random traffic with narrow targets to provoke pairs
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_warp = 3'($urandom_range(0, 1));
      req_addr = 5'($urandom_range(0, 2));
      req_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      req_data = 8'($urandom);
      init_valid = ($urandom_range(0, 19) == 0);
      init_warp = 3'($urandom);
      if (i == 1500) do_reset();
      else step();
    end
    idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pred_writeback_sequencer.md
Name: pred_writeback_sequencer

Overview:
- Write-side initiator for predicate_register_block. Drives its write port (write_en, waddr, wdata_0..7, warp_selector) from two sources: compare-unit writeback requests and warp-launch bulk clear.
- Writeback requests are buffered in a small FIFO and issued at most one write per cycle.
- A warp-init FSM zeroes all 32 predicate registers of one warp before launch.
- Sits between the execute-stage compare units and the predicate register block.

Parameters:
NUM_LANES, 8, lanes per warp; width of write_en and wdata.
NUM_REGS, 32, predicate registers per warp; waddr width is log2(NUM_REGS).
NUM_WARPS, 8, warps; warp field width is log2(NUM_WARPS).
FIFO_DEPTH, 4, writeback request buffer entries (power of 2).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  writeback request valid.
req_ready  out  1  FIFO can accept; equals !fifo_full.
req_warp  in  3  target warp.
req_addr  in  5  target predicate register.
req_mask  in  8  per-lane write enable.
req_data  in  8  per-lane predicate value; bit i goes to lane i.
init_valid  in  1  warp clear request.
init_ready  out  1  high only in IDLE with FIFO empty.
init_warp  in  3  warp to clear.
write_en  out  8  to register block write_en.
waddr  out  5  to register block waddr.
wdata  out  8  bit i drives register block wdata_i.
warp_selector  out  3  to register block warp_selector.
busy  out  1  high when the state is not IDLE or the FIFO is non-empty.
init_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset (asynchronous, rst_n low):
  - write_en, waddr, wdata, warp_selector, init_done and busy all go to 0.
  - FIFO is flushed; FSM goes to IDLE.
  - With the FIFO empty, req_ready=1 and init_ready=1.
- All outputs except req_ready and init_ready are registered.
- Push: a request is accepted on a posedge with req_valid && req_ready. There is no pass-through when full; a simultaneous pop does not free a slot within the same cycle.
- FSM states:
  - IDLE:
    - If init_valid && init_ready, go to INIT. Latch init_warp and set clear_cnt=0.
    - Otherwise, if the FIFO is non-empty, pop the head and present it in the output registers at the next edge. Latency from acceptance to write_en high is 1 cycle.
    - Otherwise, write_en=0.
  - INIT:
    - Each cycle: write_en=all 1s, wdata=0, waddr=clear_cnt, warp_selector=latched warp; clear_cnt increments.
    - After waddr=NUM_REGS-1 has been driven, the next cycle has write_en=0 and init_done=1 for exactly one cycle; FSM returns to IDLE.
    - An INIT takes exactly NUM_REGS write cycles.
    - The FIFO keeps accepting pushes during INIT but is not drained.
- Popped entry with req_mask=0: the entry is consumed and write_en stays 0 that cycle. warp_selector and waddr still update.
- A same-edge init handshake and request push are both accepted. INIT runs first; the request drains afterwards.
- FIFO order is strict FIFO. Writes to the same warp/addr are issued in acceptance order.
- When nothing is issued, write_en=0. waddr, wdata and warp_selector hold their last values.
- Reset asserted mid-INIT or mid-drain aborts immediately. No init_done pulse; queued requests are lost.
- Pointers wrap modulo FIFO_DEPTH. clear_cnt does not wrap within one INIT.

Optional Feature:
PRED_WB_MERGE_EN:
- Defined: in IDLE, if the FIFO head and the next entry are both valid with equal warp and addr, both are popped in one cycle.
  - write_en = m0|m1.
  - wdata[i] = m1[i] ? d1[i] : d0[i] (younger entry wins).
  - Only pairs merge; at most 2 entries pop per cycle.
- Undefined: exactly one entry pops per cycle.

Test Plan:
1. After reset, push {warp 3, addr 0x1F, mask 0xFF, data 0xA5} -> next cycle write_en=0xFF, waddr=0x1F, wdata=0xA5, warp_selector=3; following cycle write_en=0, busy=0.
2. init_valid with warp 5 in IDLE, FIFO empty -> 32 consecutive cycles of write_en=0xFF, wdata=0x00, waddr 0..31, warp_selector=5; init_ready=0 throughout; init_done=1 for 1 cycle right after waddr=31; then IDLE.
3. During an INIT, push 5 back-to-back requests -> req_ready drops after the 4th is accepted; the 5th waits; after init_done the 4 entries issue on 4 consecutive cycles in order; the 5th is accepted on the first pop and issues 5th.
4. Push {warp 2, addr 7, mask 0x00, data 0xFF} -> no write_en assertion; FIFO empties; busy drops 2 cycles after acceptance.
5. Assert rst_n=0 while INIT has waddr=10 with 2 requests queued -> outputs 0 immediately; no init_done; after release req_ready=1, init_ready=1, no writes issued.
6. (PRED_WB_MERGE_EN) queue {w1, a4, m 0x0F, d 0x05} then {w1, a4, m 0x3C, d 0x28} -> single write write_en=0x3F, wdata=0x29; without the macro -> two writes, 0x0F/0x05 then 0x3C/0x28.
